// File: rtl/prog_loader.sv
// Serial program loader: receives a framed, checksummed image and writes it into instruction memory.
// Never stalls the byte source; each word write lands one cycle after its low byte is accepted.
module prog_loader #(
   parameter int          ADDR_W     = 8,
   parameter int          START_ADDR = 1,
   parameter logic [7:0]  SYNC       = 8'hA5
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              cpu_rst,
   output logic              load_done,
   output logic              load_err
);

   localparam int CAP = (1 << ADDR_W) - START_ADDR;

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_H, S_LEN_L, S_DATA_H, S_DATA_L, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         len_q, len_d;
   logic [15:0]         idx_q, idx_d;
   logic [7:0]          hi_q, hi_d;
   logic [7:0]          csum_q, csum_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [15:0]         mem_wdata_q, mem_wdata_d;

   logic [15:0]         len_full;
   logic                start;

   assign len_full = {len_q[15:8], rx_data};
   assign start    = rx_valid && (rx_data == SYNC) &&
                     (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (rx_valid) begin
         case (state_q)
            S_IDLE, S_DONE, S_ERR: if (rx_data == SYNC) state_d = S_LEN_H;
            S_LEN_H:  state_d = S_LEN_L;
            S_LEN_L: begin
               if (len_full == 16'd0)
                  state_d = S_CSUM;
               else if ({16'd0, len_full} > 32'(CAP))
                  state_d = S_ERR;
               else
                  state_d = S_DATA_H;
            end
            S_DATA_H: state_d = S_DATA_L;
            S_DATA_L: state_d = (idx_q == len_q - 16'd1) ? S_CSUM : S_DATA_H;
            S_CSUM:   state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      rx_ready  = 1'b1;
      cpu_rst   = (state_q != S_DONE);
      load_done = (state_q == S_DONE);
      load_err  = (state_q == S_ERR);
      mem_we    = mem_we_q;
      mem_addr  = mem_addr_q;
      mem_wdata = mem_wdata_q;
   end

   // Datapath: length, word index, high-byte holding register, running sum, write port.
   always_comb begin
      len_d       = len_q;
      idx_d       = idx_q;
      hi_d        = hi_q;
      csum_d      = csum_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (start) begin
         idx_d  = 16'd0;
         csum_d = 8'd0;
      end
      if (rx_valid) begin
         case (state_q)
            S_LEN_H: len_d[15:8] = rx_data;
            S_LEN_L: len_d       = len_full;
            S_DATA_H: begin
               hi_d   = rx_data;
               csum_d = csum_q + rx_data;
            end
            S_DATA_L: begin
               csum_d      = csum_q + rx_data;
               idx_d       = idx_q + 16'd1;
               mem_we_d    = 1'b1;
               mem_addr_d  = ADDR_W'(START_ADDR + 32'(idx_q));
               mem_wdata_d = {hi_q, rx_data};
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         len_q       <= 16'd0;
         idx_q       <= 16'd0;
         hi_q        <= 8'd0;
         csum_q      <= 8'd0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 16'd0;
      end else begin
         len_q       <= len_d;
         idx_q       <= idx_d;
         hi_q        <= hi_d;
         csum_q      <= csum_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame-level reference model plus per-cycle output comparison.
module tb_prog_loader;

   localparam int         ADDR_W = 8;
   localparam int         START  = 1;
   localparam logic [7:0] SYNC   = 8'hA5;
   localparam int         CAP    = (1 << ADDR_W) - START;

   logic              CLK = 1'b0;
   logic              rst = 1'b0;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic              cpu_rst;
   logic              load_done;
   logic              load_err;

   prog_loader #(.ADDR_W(ADDR_W), .START_ADDR(START), .SYNC(SYNC)) dut (
      .CLK(CLK), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_rst(cpu_rst), .load_done(load_done), .load_err(load_err)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: position within the frame byte stream, not loader states.
   int         pos;          // 0 = hunting for SYNC, 1/2 = length bytes, 3.. = payload then checksum
   int         n_words;
   int         widx;
   int         status;       // 0 = no verdict, 1 = loaded ok, 2 = aborted
   logic [7:0] msum, mhi;
   int         expq[$];      // expected writes as {addr, data}

   task automatic model_reset();
      pos = 0; n_words = 0; widx = 0; status = 0; msum = 8'h00; mhi = 8'h00;
      expq.delete();
   endtask

   task automatic model_step(input logic [7:0] b);
      int k;
      if (pos == 0) begin
         if (b == SYNC) begin
            pos = 1; msum = 8'h00; widx = 0; status = 0;
         end
      end else if (pos == 1) begin
         n_words = int'(b) * 256; pos = 2;
      end else if (pos == 2) begin
         n_words = n_words + int'(b);
         if (n_words > CAP) begin
            status = 2; pos = 0;
         end else begin
            pos = 3;
         end
      end else begin
         k = pos - 3;
         if (k < 2 * n_words) begin
            msum = msum + b;
            if (k % 2 == 0) mhi = b;
            else begin
               expq.push_back(((START + widx) << 16) | {16'h0, mhi, b});
               widx++;
            end
            pos++;
         end else begin
            status = (b == msum) ? 1 : 2;
            pos = 0;
         end
      end
   endtask

   // Shadow of the instruction memory, filled from the DUT write port.
   logic [15:0] shadow [0:255];
   int          wcount = 0;

   always @(negedge CLK) begin
      if (chk_en) begin
         chk("rx_ready", rx_ready, 1);
         chk("cpu_rst", cpu_rst, status != 1);
         chk("load_done", load_done, status == 1);
         chk("load_err", load_err, status == 2);
         chk("mem_we", mem_we, expq.size() != 0);
         if (expq.size() != 0) begin
            int e;
            e = expq.pop_front();
            if (mem_we) begin
               chk("mem_addr", 32'(mem_addr), e >> 16);
               chk("mem_wdata", 32'(mem_wdata), e & 32'hFFFF);
            end
         end
         if (mem_we) begin
            shadow[mem_addr] = mem_wdata;
            wcount++;
         end
      end
   end

   task automatic cyc(input logic v, input logic [7:0] b, input logic r);
      rx_valid = v; rx_data = b; rst = r;
      @(posedge CLK);
      if (r) model_reset();
      else if (v) model_step(b);
      @(negedge CLK);
      rx_valid = 1'b0; rst = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      cyc(1'b1, b, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
   endtask

   logic [7:0] frm[$];
   task automatic send_frm();
      foreach (frm[i]) send(frm[i]);
   endtask

   int w0;

   initial begin
      for (int i = 0; i < 256; i++) shadow[i] = 16'hDEAD;
      model_reset();
      rx_valid = 1'b0; rst = 1'b1;
      @(posedge CLK); @(posedge CLK); @(negedge CLK);
      chk_en = 1'b1;
      cyc(1'b0, 8'h00, 1'b1);
      chk("rst_cpu_rst", cpu_rst, 1);
      chk("rst_done", load_done, 0);
      chk("rst_err", load_err, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_wdata", 32'(mem_wdata), 0);

      // Good frame with source gaps mid-frame
      send(8'hA5); send(8'h00); idle(5);
      send(8'h04); send(8'h81); send(8'h07); idle(3);
      frm = '{8'h82, 8'h05, 8'h11, 8'h20, 8'hFF, 8'hFF};
      send_frm();
      chk("pre_csum_cpu_rst", cpu_rst, 1);
      send(8'h3E);
      chk("good_cpu_rst_fell", cpu_rst, 0);
      chk("good_done", load_done, 1);
      idle(2);
      chk("good_w1", 32'(shadow[1]), 32'h8107);
      chk("good_w2", 32'(shadow[2]), 32'h8205);
      chk("good_w3", 32'(shadow[3]), 32'h1120);
      chk("good_w4", 32'(shadow[4]), 32'hFFFF);
      chk("good_wcount", wcount, 4);

      // Reload from DONE
      send(8'hA5);
      chk("reload_cpu_rst_rose", cpu_rst, 1);
      chk("reload_done_low", load_done, 0);
      frm = '{8'h00, 8'h01, 8'hAB, 8'hCD, 8'h78};
      send_frm(); idle(2);
      chk("reload_w1", 32'(shadow[1]), 32'hABCD);
      chk("reload_done", load_done, 1);

      // Bad checksum: writes stay, error flagged
      w0 = wcount;
      frm = '{8'hA5, 8'h00, 8'h04, 8'h81, 8'h07, 8'h82, 8'h05, 8'h11, 8'h20, 8'hFF, 8'hFF, 8'h3F};
      send_frm(); idle(2);
      chk("badsum_wcount", wcount - w0, 4);
      chk("badsum_err", load_err, 1);
      chk("badsum_cpu_rst", cpu_rst, 1);
      chk("badsum_done", load_done, 0);
      chk("badsum_w1_kept", 32'(shadow[1]), 32'h8107);

      // Length overflow: N = 256 against capacity 255
      w0 = wcount;
      frm = '{8'hA5, 8'h01, 8'h00, 8'h12, 8'h34};
      send_frm(); idle(2);
      chk("ovf_err", load_err, 1);
      chk("ovf_wcount", wcount - w0, 0);

      // Garbage before an empty frame
      cyc(1'b0, 8'h00, 1'b1);
      w0 = wcount;
      frm = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00, 8'h00, 8'h00};
      send_frm(); idle(2);
      chk("empty_done", load_done, 1);
      chk("empty_wcount", wcount - w0, 0);

      // Reset mid-frame, then replay
      frm = '{8'hA5, 8'h00, 8'h04, 8'h81};
      send_frm();
      cyc(1'b0, 8'h00, 1'b1);
      chk("midrst_cpu_rst", cpu_rst, 1);
      chk("midrst_addr", 32'(mem_addr), 0);
      chk("midrst_wdata", 32'(mem_wdata), 0);
      w0 = wcount;
      frm = '{8'h07, 8'h82, 8'h05};
      send_frm(); idle(2);
      chk("midrst_nowrites", wcount - w0, 0);
      frm = '{8'hA5, 8'h00, 8'h04, 8'h81, 8'h07, 8'h82, 8'h05, 8'h11, 8'h20, 8'hFF, 8'hFF, 8'h3E};
      send_frm(); idle(2);
      chk("replay_done", load_done, 1);
      chk("replay_wcount", wcount - w0, 4);

      // Reset coinciding with a low-byte accept suppresses that write
      frm = '{8'hA5, 8'h00, 8'h01, 8'hAB};
      send_frm();
      w0 = wcount;
      cyc(1'b1, 8'hCD, 1'b1);
      idle(2);
      chk("rst_suppress_we", wcount - w0, 0);

      // SYNC value inside payload is data
      frm = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'h4A};
      send_frm(); idle(2);
      chk("syncdata_w1", 32'(shadow[1]), 32'hA5A5);
      chk("syncdata_done", load_done, 1);

      // Full-capacity frame: N = 255, word i = {i, ~i}, sum of 510 bytes = 255*255 mod 256 = 01
      w0 = wcount;
      send(8'hA5); send(8'h00); send(8'hFF);
      for (int i = 0; i < 255; i++) begin
         send(8'(i)); send(~8'(i));
      end
      send(8'h01); idle(2);
      chk("cap_done", load_done, 1);
      chk("cap_wcount", wcount - w0, 255);
      chk("cap_w255", 32'(shadow[255]), 32'hFE01);
      chk("cap_w1", 32'(shadow[1]), 32'h00FF);
      chk("addr0_untouched", 32'(shadow[0]), 32'hDEAD);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory address width in 16-bit words.
REQ-002 Parameter START_ADDR, default 1, address of the first loaded word; address 0 is left untouched.
REQ-003 Parameter SYNC, default 8'hA5, frame start byte.
REQ-004 CLK  input  1  single system clock; all state changes on posedge CLK.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 rx_valid  input  1  byte available on rx_data.
REQ-007 rx_data  input  8  received byte.
REQ-008 rx_ready  output  1  loader accepts a byte this cycle; a byte transfers when rx_valid && rx_ready.
REQ-009 mem_we  output  1  single-cycle write strobe to the fetch-stage instruction memory.
REQ-010 mem_addr  output  ADDR_W  word address for mem_we.
REQ-011 mem_wdata  output  16  instruction word for mem_we.
REQ-012 cpu_rst  output  1  holds the downstream CPU in reset while high.
REQ-013 load_done  output  1  last frame loaded with a good checksum.
REQ-014 load_err  output  1  last frame aborted (length overflow or bad checksum).

Function
REQ-015 Frame format SHALL be: SYNC, LEN_H, LEN_L (16-bit word count N), then N words sent high byte first, then CSUM = 8-bit modulo-256 sum of the 2N data bytes only.
REQ-016 FSM states SHALL be IDLE, LEN_H, LEN_L, DATA_H, DATA_L, CSUM, DONE, ERR; transitions occur only on an accepted byte.
REQ-017 IDLE: SYNC -> LEN_H; any other byte is discarded, state unchanged.
REQ-018 LEN_H -> LEN_L; LEN_L -> DATA_H if 0 < N <= 2**ADDR_W - START_ADDR, -> CSUM if N == 0, -> ERR if N exceeds capacity.
REQ-019 DATA_H latches the high byte -> DATA_L; DATA_L -> DATA_H while words remain, -> CSUM after word N.
REQ-020 The cycle after a DATA_L accept, mem_we SHALL be 1 for exactly one cycle with mem_addr = START_ADDR + word index (0-based) and mem_wdata = {high byte, low byte}.
REQ-021 The word index and running checksum SHALL clear on every SYNC accept that starts a frame.
REQ-022 CSUM: byte equal to the running sum -> DONE; otherwise -> ERR.
REQ-023 rx_ready SHALL be 1 in every state; the loader never stalls the byte source.
REQ-024 cpu_rst SHALL be 1 in all states except DONE; it falls the cycle after the matching CSUM accept.
REQ-025 load_done SHALL be 1 exactly while in DONE; load_err SHALL be 1 exactly while in ERR.
REQ-026 In DONE or ERR, a SYNC byte SHALL start a new frame (-> LEN_H, cpu_rst back to 1, load_done/load_err to 0 the next cycle); other bytes are ignored.
REQ-027 A data byte equal to SYNC inside a frame SHALL be treated as data, not as a restart.
REQ-028 rx_valid low mid-frame SHALL hold all state indefinitely (no timeout).
REQ-029 Words already written before an ERR SHALL stay in memory; no rollback.

Reset
REQ-030 On rst high at a posedge: state IDLE, cpu_rst = 1, load_done = 0, load_err = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, word index and checksum = 0.
REQ-031 rst SHALL override any simultaneous byte accept; a frame interrupted by rst is abandoned and a pending mem_we is suppressed.

Verification
REQ-032 Bytes A5 00 04 81 07 82 05 11 20 FF FF 3E -> writes [1]=8107, [2]=8205, [3]=1120, [4]=FFFF; load_done = 1; cpu_rst falls one cycle after 3E.
REQ-033 Same frame with CSUM 3F -> four writes occur, then load_err = 1, cpu_rst stays 1, load_done = 0.
REQ-034 A5 01 00 (N = 256, capacity 255) -> ERR after LEN_L; no mem_we pulses.
REQ-035 Garbage bytes 00 FF 12 before A5 00 00 00 -> garbage ignored, zero writes, DONE reached.
REQ-036 rst asserted after the 81 byte of REQ-032's frame -> IDLE, cpu_rst = 1, no further writes; replaying the full frame then succeeds.
REQ-037 From DONE, send A5 00 01 AB CD 78 -> cpu_rst rises the cycle after A5, [1]=ABCD written, DONE again.
